// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: 640x480@60 timing constants, lock FSM encoding and counter helper shared with the DAC generator
package vga_timing_pkg;
  localparam logic [9:0] H_SYNC  = 10'd96;
  localparam logic [9:0] H_BACK  = 10'd40;
  localparam logic [9:0] H_LEFT  = 10'd8;
  localparam logic [9:0] H_VALID = 10'd640;
  localparam logic [9:0] H_TOTAL = 10'd800;
  localparam logic [9:0] V_SYNC  = 10'd2;
  localparam logic [9:0] V_BACK  = 10'd25;
  localparam logic [9:0] V_TOP   = 10'd8;
  localparam logic [9:0] V_VALID = 10'd480;
  localparam logic [9:0] V_TOTAL = 10'd525;
  localparam logic [9:0] ACT_X0  = H_SYNC + H_BACK + H_LEFT;
  localparam logic [9:0] ACT_Y0  = V_SYNC + V_BACK + V_TOP;
  localparam logic [9:0] CNT_MAX = 10'h3FF;
  typedef enum logic [1:0] {SEARCH = 2'd0, VERIFY = 2'd1, LOCKED = 2'd2} lock_state_t;
  // Counters stick at all-ones so a missing sync never aliases into a plausible length.
  function automatic logic [9:0] sat_inc(input logic [9:0] v);
    return (v == CNT_MAX) ? CNT_MAX : v + 10'd1;
  endfunction
endpackage

// File: rtl/vga_sync_edge.sv
// vga_sync_edge: registers incoming hsync/vsync and flags their rising edges one cycle later
module vga_sync_edge (
  input  logic vga_clk,
  input  logic sys_rst_n,
  input  logic hsync,
  input  logic vsync,
  output logic hs_rise,
  output logic vs_rise
);
  logic hs_r, vs_r, hs_d, vs_d;
  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      hs_r <= 1'b0;
      vs_r <= 1'b0;
      hs_d <= 1'b0;
      vs_d <= 1'b0;
    end else begin
      hs_r <= hsync;
      vs_r <= vsync;
      hs_d <= hs_r;
      vs_d <= vs_r;
    end
  end
  assign hs_rise = hs_r & ~hs_d;
  assign vs_rise = vs_r & ~vs_d;
endmodule

// File: rtl/vga_rx_capture.sv
// vga_rx_capture: recovers VGA timing from sync inputs, locks after consecutive good frames, emits active pixels with x/y
module vga_rx_capture
  import vga_timing_pkg::*;
#(
  parameter int unsigned LOCK_FRAMES = 2,
  parameter logic [9:0]  H_ACT0      = ACT_X0,
  parameter logic [9:0]  H_ACT       = H_VALID,
  parameter logic [9:0]  H_TOT       = H_TOTAL,
  parameter logic [9:0]  V_ACT0      = ACT_Y0,
  parameter logic [9:0]  V_ACT       = V_VALID,
  parameter logic [9:0]  V_TOT       = V_TOTAL
) (
  input  logic        vga_clk,
  input  logic        sys_rst_n,
  input  logic        hsync,
  input  logic        vsync,
  input  logic [7:0]  vga_r,
  input  logic [7:0]  vga_g,
  input  logic [7:0]  vga_b,
  output logic [23:0] pix_data,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic        pix_valid,
  output logic        frame_start,
  output logic        locked,
  output logic        lock_err,
  output logic [9:0]  h_total_meas,
  output logic [9:0]  v_total_meas
);
  localparam logic [3:0] LOCK_N = 4'(LOCK_FRAMES);
  localparam logic [9:0] H_ACT1 = H_ACT0 + H_ACT;
  localparam logic [9:0] V_ACT1 = V_ACT0 + V_ACT;
  logic        hs_rise, vs_rise;
  logic [23:0] rgb_r;
  logic [9:0]  h_pos, v_pos, h_nxt, v_nxt, h_len, v_len;
  logic        seen_h, vs_pend, line_bad;
  logic        v_reset, bad_line, frame_ok, in_win, out_en;
  logic [3:0]  ok_cnt, ok_cnt_nxt;
  lock_state_t state, state_nxt;

  vga_sync_edge u_edge (
    .vga_clk  (vga_clk),
    .sys_rst_n(sys_rst_n),
    .hsync    (hsync),
    .vsync    (vsync),
    .hs_rise  (hs_rise),
    .vs_rise  (vs_rise)
  );

  // h_nxt/v_nxt are the coordinates of the pixel now in rgb_r, so the output stage stays aligned with colour.
  always_comb begin
    h_len    = sat_inc(h_pos);
    v_len    = sat_inc(v_pos);
    v_reset  = hs_rise & (vs_pend | vs_rise);
    h_nxt    = hs_rise ? 10'd0 : h_len;
    v_nxt    = v_reset ? 10'd0 : hs_rise ? v_len : v_pos;
    bad_line = hs_rise & seen_h & (h_len != H_TOT);
    frame_ok = ~line_bad & ~bad_line & (v_len == V_TOT);
    in_win   = (h_nxt >= H_ACT0) && (h_nxt < H_ACT1) && (v_nxt >= V_ACT0) && (v_nxt < V_ACT1);
    out_en   = (state_nxt == LOCKED) & in_win;
  end

  always_comb begin
    state_nxt  = state;
    ok_cnt_nxt = ok_cnt;
    case (state)
      SEARCH: if (v_reset) begin
        state_nxt  = VERIFY;
        ok_cnt_nxt = 4'd0;
      end
      VERIFY: if (v_reset) begin
        ok_cnt_nxt = frame_ok ? ok_cnt + 4'd1 : 4'd0;
        state_nxt  = (frame_ok && (ok_cnt + 4'd1 == LOCK_N)) ? LOCKED : VERIFY;
      end
      LOCKED: state_nxt = (bad_line || (v_reset && !frame_ok)) ? SEARCH : LOCKED;
      default: state_nxt = SEARCH;
    endcase
  end

  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rgb_r        <= '0;
      h_pos        <= '0;
      v_pos        <= '0;
      seen_h       <= 1'b0;
      vs_pend      <= 1'b0;
      line_bad     <= 1'b0;
      state        <= SEARCH;
      ok_cnt       <= '0;
      h_total_meas <= '0;
      v_total_meas <= '0;
    end else begin
      rgb_r    <= {vga_r, vga_g, vga_b};
      h_pos    <= h_nxt;
      v_pos    <= v_nxt;
      seen_h   <= seen_h | hs_rise;
      vs_pend  <= hs_rise ? 1'b0 : (vs_pend | vs_rise);
      line_bad <= v_reset ? 1'b0 : (line_bad | bad_line);
      state    <= state_nxt;
      ok_cnt   <= ok_cnt_nxt;
      if (hs_rise && seen_h) h_total_meas <= h_len;
      if (v_reset) v_total_meas <= v_len;
    end
  end

  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      pix_data    <= '0;
      pix_x       <= CNT_MAX;
      pix_y       <= CNT_MAX;
      pix_valid   <= 1'b0;
      frame_start <= 1'b0;
      lock_err    <= 1'b0;
    end else begin
      pix_data    <= out_en ? rgb_r : 24'd0;
      pix_x       <= out_en ? h_nxt - H_ACT0 : CNT_MAX;
      pix_y       <= out_en ? v_nxt - V_ACT0 : CNT_MAX;
      pix_valid   <= out_en;
      frame_start <= out_en & (h_nxt == H_ACT0) & (v_nxt == V_ACT0);
      lock_err    <= (state == LOCKED) & (state_nxt == SEARCH);
    end
  end

  assign locked = (state == LOCKED);
endmodule

// File: tb/tb_vga_rx_capture.sv
// tb_vga_rx_capture: scaled-timing loopback generator feeding a pixel scoreboard plus directed lock/measurement checks
module tb_vga_rx_capture;
  localparam int HS = 4, X0 = 8, HV = 16, HT = 32;
  localparam int VS = 1, Y0 = 4, VV = 8, VT = 16;
  typedef struct packed {
    logic [9:0]  x;
    logic [9:0]  y;
    logic [23:0] d;
    logic [31:0] c;
  } exp_t;

  logic        vga_clk = 1'b0;
  logic        sys_rst_n = 1'b1;
  logic        hsync = 1'b0, vsync = 1'b0;
  logic [7:0]  vga_r = '0, vga_g = '0, vga_b = '0;
  logic [23:0] pix_data;
  logic [9:0]  pix_x, pix_y, h_total_meas, v_total_meas;
  logic        pix_valid, frame_start, locked, lock_err;

  exp_t exp_q[$];
  exp_t em;
  int checks = 0, errors = 0;
  int cyc = 0, valid_cnt = 0, fs_cnt = 0, lerr_cnt = 0, lerr_cyc = -1, rel_cyc = -2;

  vga_rx_capture #(
    .LOCK_FRAMES(2), .H_ACT0(10'(X0)), .H_ACT(10'(HV)), .H_TOT(10'(HT)),
    .V_ACT0(10'(Y0)), .V_ACT(10'(VV)), .V_TOT(10'(VT))
  ) dut (
    .vga_clk(vga_clk), .sys_rst_n(sys_rst_n), .hsync(hsync), .vsync(vsync),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b), .pix_data(pix_data),
    .pix_x(pix_x), .pix_y(pix_y), .pix_valid(pix_valid), .frame_start(frame_start),
    .locked(locked), .lock_err(lock_err), .h_total_meas(h_total_meas), .v_total_meas(v_total_meas)
  );

  always #5 vga_clk = ~vga_clk;
  always @(posedge vga_clk) cyc <= cyc + 1;

  always @(negedge vga_clk) begin
    if (lock_err) begin
      lerr_cnt++;
      lerr_cyc = cyc;
    end
    if (frame_start) fs_cnt++;
    checks++;
    if (pix_valid) begin
      valid_cnt++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pixel got x=%0d y=%0d d=%h at cyc %0d, required no pixel", pix_x, pix_y, pix_data, cyc);
      end else begin
        em = exp_q.pop_front();
        if ({pix_x, pix_y, pix_data, frame_start} !== {em.x, em.y, em.d, (em.x == 0 && em.y == 0)} || cyc != int'(em.c) + 2) begin
          errors++;
          $display("FAIL pixel got x=%0d y=%0d d=%h fs=%b cyc=%0d required x=%0d y=%0d d=%h fs=%b cyc=%0d",
                   pix_x, pix_y, pix_data, frame_start, cyc, em.x, em.y, em.d, (em.x == 0 && em.y == 0), int'(em.c) + 2);
        end
      end
    end else if ({pix_x, pix_y, pix_data, frame_start} !== {10'h3FF, 10'h3FF, 24'h0, 1'b0}) begin
      errors++;
      $display("FAIL idle_outputs got x=%h y=%h d=%h fs=%b required 3ff 3ff 0 0", pix_x, pix_y, pix_data, frame_start);
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s got %0h required %0h", name, got, req);
    end
  endtask

  // Lines l0..l1-1 of a frame; line 'stretch' gets one extra blank clock; pixels on lines <= exp_last are expected out.
  task automatic drive_lines(input int l0, input int l1, input int stretch, input int exp_last);
    int len, xx, yy;
    bit act;
    exp_t e;
    for (int v = l0; v < l1; v++) begin
      len = (v == stretch) ? HT + 1 : HT;
      for (int h = 0; h < len; h++) begin
        @(posedge vga_clk);
        #1;
        if (h == 0 && stretch >= 0 && v == stretch + 1) rel_cyc = cyc;
        hsync = (h < HS);
        vsync = (v < VS);
        act = (h >= X0) && (h < X0 + HV) && (v >= Y0) && (v < Y0 + VV);
        xx = h - X0;
        yy = v - Y0;
        {vga_r, vga_g, vga_b} = act ? {8'(xx), 8'(yy), 8'h5A} : 24'hFFFFFF;
        if (act && v <= exp_last) begin
          e.x = 10'(xx);
          e.y = 10'(yy);
          e.d = {8'(xx), 8'(yy), 8'h5A};
          e.c = 32'(cyc);
          exp_q.push_back(e);
        end
      end
    end
  endtask

  task automatic frame(input int lines, input bit expect_pix);
    drive_lines(0, lines, -1, expect_pix ? VT : -1);
  endtask

  initial begin
    #2 sys_rst_n = 1'b0;
    #1;
    chk("reset_pix", {pix_valid, frame_start, locked, lock_err, pix_data}, 28'h0);
    chk("reset_xy", {pix_x, pix_y}, {10'h3FF, 10'h3FF});
    chk("reset_meas", {h_total_meas, v_total_meas}, 20'h0);
    repeat (3) @(posedge vga_clk);
    #1 sys_rst_n = 1'b1;
    frame(VT, 1'b0);
    frame(VT, 1'b0);
    chk("unlocked_before_3rd_edge", locked, 0);
    chk("v_meas_first", v_total_meas, VT);
    chk("h_meas_first", h_total_meas, HT);
    frame(VT, 1'b1);
    chk("locked_after_3rd_edge", locked, 1);
    chk("valid_count_frame", valid_cnt, HV * VV);
    chk("frame_start_count", fs_cnt, 1);
    drive_lines(0, 12, 10, 10);
    chk("h_meas_stretched", h_total_meas, HT + 1);
    chk("lock_err_count", lerr_cnt, 1);
    chk("lock_err_cycle", lerr_cyc, rel_cyc + 2);
    chk("unlocked_after_stretch", locked, 0);
    drive_lines(12, VT, -1, -1);
    frame(VT, 1'b0);
    frame(VT, 1'b0);
    chk("relock_pending", locked, 0);
    chk("queue_drained_stretch", exp_q.size(), 0);
    frame(VT, 1'b1);
    chk("relocked", locked, 1);
    drive_lines(0, 6, -1, VT);
    #2 sys_rst_n = 1'b0;
    #1;
    chk("midrst_pix", {pix_valid, frame_start, locked, lock_err, pix_data}, 28'h0);
    chk("midrst_xy", {pix_x, pix_y}, {10'h3FF, 10'h3FF});
    chk("midrst_meas", {h_total_meas, v_total_meas}, 20'h0);
    chk("midrst_queue", exp_q.size(), 0);
    repeat (2) @(posedge vga_clk);
    #1 sys_rst_n = 1'b1;
    drive_lines(6, VT, -1, -1);
    frame(VT, 1'b0);
    frame(VT, 1'b0);
    chk("rst_relock_pending", locked, 0);
    frame(VT, 1'b1);
    chk("rst_relocked", locked, 1);
    frame(VT - 1, 1'b1);
    frame(VT - 1, 1'b0);
    chk("short_frame_lock_err", lerr_cnt, 2);
    frame(VT - 1, 1'b0);
    frame(VT - 1, 1'b0);
    chk("short_v_meas", v_total_meas, VT - 1);
    chk("short_never_locks", locked, 0);
    frame(VT - 1, 1'b0);
    chk("short_still_unlocked", locked, 0);
    @(posedge vga_clk);
    #1 {hsync, vsync, vga_r, vga_g, vga_b} = '0;
    repeat (2000) @(posedge vga_clk);
    drive_lines(0, 1, -1, -1);
    chk("h_meas_saturated", h_total_meas, 10'h3FF);
    chk("hold_unlocked", locked, 0);
    repeat (4) @(posedge vga_clk);
    chk("final_queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
